// File: rtl/uart_rx_16x.sv
// UART receiver clocked by a 16x oversampling tick.
// Mid-cell sampling, optional parity, stop check, valid/ready byte port.
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);
    localparam logic       PAR_EN   = (PARITY_EN != 0);

    logic                 sync1_q;
    logic                 rx_s_q;

    state_t               state_q,    state_d;
    logic [3:0]           cnt_q,      cnt_d;
    logic [2:0]           idx_q,      idx_d;
    logic                 armed_q,    armed_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 perr_q,     perr_d;
    logic                 ferr_q,     ferr_d;
    logic                 deliver_q,  deliver_d;

    logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_q,    frame_d;
    logic                 parity_q,   parity_d;
    logic                 overrun_q,  overrun_d;

    logic                 mid_cell;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    assign mid_cell = (cnt_q == 4'd15);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        armed_d   = armed_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        deliver_d = 1'b0;
        if (tick_16x) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end
                    if (armed_q && !rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = 4'd0;
                        perr_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        idx_d = 3'd0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (mid_cell) begin
                        // LSB arrives first, so shift in from the top.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) begin
                            state_d = PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (mid_cell) begin
                        perr_d  = rx_s_q != ((^shift_q) ^ PAR_ODD);
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (mid_cell) begin
                        ferr_d    = ~rx_s_q;
                        deliver_d = 1'b1;
                        // A low stop bit disarms so a break gives one error only.
                        armed_d   = rx_s_q;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 3'd0;
            armed_q   <= 1'b0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            deliver_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            armed_q   <= armed_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            deliver_q <= deliver_d;
        end
    end

    // Holding register: a new frame wins only if the slot is free or being taken.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        frame_d    = frame_q;
        parity_d   = parity_q;
        overrun_d  = 1'b0;
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                frame_d    = ferr_q;
                parity_d   = perr_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            frame_q    <= 1'b0;
            parity_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            frame_q    <= frame_d;
            parity_q   <= parity_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_q;
    assign parity_err = parity_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule
